// File: rtl/reflet_tone_detector_pkg.sv
// Shared constants for the tone detector: bus address, status register layout,
// period counter geometry and search FSM encodings.
package reflet_tone_detector_pkg;

  localparam logic [15:0] SYNTH_ADDR  = 16'hFF21;
  localparam logic [15:0] ADDR_OFFSET = 16'h0001;

  localparam int VALID_BIT = 7;
  localparam int NEW_BIT   = 6;
  localparam int TONE_MSB  = 5;
  localparam int TONE_LSB  = 0;

  localparam int              CNT_W     = 14;
  localparam logic [CNT_W-1:0] CNT_MAX  = 14'd16383;
  localparam logic [5:0]       TONE_LAST = 6'd63;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/reflet_counter.sv
// Free-running wrap-around counter; at_max marks the last count of each wrap.
module reflet_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  assign at_max = (count == WIDTH'(MAX));

  always_ff @(posedge clk) begin
    if (!reset)
      count <= '0;
    else if (enable)
      count <= at_max ? '0 : count + WIDTH'(1);
  end

endmodule

// File: rtl/reflet_tone_threshold_map.sv
// Registered lookup of the tone decision thresholds: midpoints between adjacent
// synth divisors, th[63]=0 so the final compare always matches.
module reflet_tone_threshold_map
  import reflet_tone_detector_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       select,
  output logic [CNT_W-1:0] out
);

  localparam logic [CNT_W-1:0] TH [64] = '{
    14'd14026, 14'd13238, 14'd12495, 14'd11794, 14'd11132, 14'd10507, 14'd9917, 14'd9361,
    14'd8836,  14'd8340,  14'd7872,  14'd7430,  14'd7012,  14'd6619,  14'd6247, 14'd5897,
    14'd5566,  14'd5253,  14'd4959,  14'd4680,  14'd4417,  14'd4170,  14'd3936, 14'd3715,
    14'd3506,  14'd3309,  14'd3124,  14'd2948,  14'd2783,  14'd2627,  14'd2479, 14'd2340,
    14'd2209,  14'd2085,  14'd1968,  14'd1857,  14'd1753,  14'd1655,  14'd1562, 14'd1474,
    14'd1391,  14'd1313,  14'd1240,  14'd1170,  14'd1104,  14'd1042,  14'd984,  14'd929,
    14'd876,   14'd827,   14'd781,   14'd737,   14'd696,   14'd657,   14'd620,  14'd585,
    14'd552,   14'd521,   14'd492,   14'd464,   14'd438,   14'd414,   14'd390,  14'd0
  };

  always_ff @(posedge clk) begin
    if (!reset)
      out <= '0;
    else
      out <= TH[select];
  end

endmodule

// File: rtl/reflet_tone_detector.sv
// Measures the period of tone_in in 1 us ticks and resolves it to the nearest
// synth tone index by a linear search of the threshold table.
module reflet_tone_detector
  import reflet_tone_detector_pkg::*;
#(
  parameter int                        base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr      = base_addr_size'(SYNTH_ADDR + ADDR_OFFSET),
  parameter int                        clk_freq       = 1000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic                      write_en,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out,
  input  logic                      tone_in
);

  localparam int TICK_DIV = clk_freq / 1000000;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic             tick, edge_rise, accept, timeout, selected;
  logic             sync_p0, sync_p1, prev_p2;
  logic             edge_seen, valid, new_flag;
  logic [5:0]       tone, cmp_idx, cmp_next, select;
  logic [CNT_W-1:0] count, period, period_next, th;
  logic [PRE_W-1:0] unused_pre_count;
  logic             unused_data_in;
  state_t           state, state_next;

  assign unused_data_in = ^data_in;

  reflet_counter #(.WIDTH(PRE_W), .MAX(TICK_DIV - 1)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (1'b1),
    .count  (unused_pre_count),
    .at_max (tick)
  );

  reflet_tone_threshold_map u_th_map (
    .clk    (clk),
    .reset  (reset),
    .select (select),
    .out    (th)
  );

  // Stage p0/p1: synchroniser; p2: previous sample for rising-edge detect
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= tone_in;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign edge_rise = sync_p1 & ~prev_p2;
  // One-shot on the tick that lands the counter on its saturation value
  assign timeout   = tick && !edge_rise && (count == CNT_MAX - CNT_W'(1));
  assign accept    = edge_rise && edge_seen && (count != CNT_MAX) && (state == IDLE);
  assign selected  = enable && (addr == base_addr);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count     <= '0;
      edge_seen <= 1'b0;
    end else begin
      if (edge_rise)
        count <= '0;
      else if (tick && count != CNT_MAX)
        count <= count + CNT_W'(1);
      if (edge_rise)
        edge_seen <= 1'b1;
      else if (timeout)
        edge_seen <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      period  <= '0;
      cmp_idx <= '0;
    end else begin
      state   <= state_next;
      period  <= period_next;
      cmp_idx <= cmp_next;
    end
  end

  // The table answers one cycle late, so the issued index runs one ahead of cmp_idx
  always_comb begin
    state_next  = state;
    period_next = period;
    cmp_next    = cmp_idx;
    select      = 6'd0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next  = SEARCH;
          period_next = count;
          cmp_next    = 6'd0;
        end
      end
      SEARCH: begin
        select = cmp_idx + 6'd1;
        if (period > th || cmp_idx == TONE_LAST)
          state_next = DONE;
        else
          cmp_next = cmp_idx + 6'd1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A result landing in the same cycle as a clearing write keeps new set
  always_ff @(posedge clk) begin
    if (!reset) begin
      tone     <= '0;
      valid    <= 1'b0;
      new_flag <= 1'b0;
    end else begin
      if (timeout)
        valid <= 1'b0;
      if (selected && write_en)
        new_flag <= 1'b0;
      if (state == DONE) begin
        tone     <= cmp_idx;
        valid    <= 1'b1;
        new_flag <= 1'b1;
      end
    end
  end

  always_comb begin
    data_out = '0;
    if (selected) begin
      data_out[VALID_BIT]          = valid;
      data_out[NEW_BIT]            = new_flag;
      data_out[TONE_MSB:TONE_LSB]  = tone;
    end
  end

endmodule

// File: tb/tb_reflet_tone_detector.sv
// Directed bench for reflet_tone_detector: table of edge gaps with expected
// status bytes, plus hand sequences for search-time edges, DONE writes and reset.
module tb_reflet_tone_detector;

  localparam logic [15:0] BASE = 16'hFF22;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] addr = '0;
  logic        write_en = 1'b0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic        tone_in = 1'b0;

  logic        enable2 = 1'b1;
  logic [15:0] addr2 = BASE;
  logic        write_en2 = 1'b0;
  logic [7:0]  data_in2 = '0;
  logic [7:0]  data_out2;
  logic        tone2 = 1'b0;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  reflet_tone_detector #(.base_addr_size(16), .base_addr(BASE), .clk_freq(1000000)) dut (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr), .write_en(write_en),
    .data_in(data_in), .data_out(data_out), .tone_in(tone_in)
  );

  reflet_tone_detector #(.base_addr_size(16), .base_addr(BASE), .clk_freq(4000000)) dut4 (
    .clk(clk), .reset(reset), .enable(enable2), .addr(addr2), .write_en(write_en2),
    .data_in(data_in2), .data_out(data_out2), .tone_in(tone2)
  );

  // gap: clocks from this row's rising edge to the next one; the detector
  // counts gap-1 ticks at 1 MHz. exp is read 80 clocks after this row's edge.
  typedef struct {
    int         gap;
    bit         pre;
    logic [7:0] pre_exp;
    logic [7:0] exp;
    bit         wr;
  } row_t;

  row_t rows[10];

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: data_out=%02h expected=%02h", name, act, exp);
    end
  endtask

  task automatic read_chk(input logic en, input logic [15:0] a, input logic [7:0] exp,
                          input string name);
    enable   = en;
    addr     = a;
    write_en = 1'b0;
    #1;
    check(name, data_out, exp);
    enable = 1'b0;
    addr   = '0;
  endtask

  task automatic bus_write(input logic [15:0] a);
    enable   = 1'b1;
    addr     = a;
    write_en = 1'b1;
    data_in  = 8'h55;
    cycles(1);
    write_en = 1'b0;
    enable   = 1'b0;
    addr     = '0;
    data_in  = '0;
  endtask

  initial begin
    rows[0] = '{2273,  1'b0, 8'h00, 8'h00, 1'b0}; // first edge only arms
    rows[1] = '{16001, 1'b0, 8'h00, 8'hE0, 1'b1}; // 2272 -> 32
    rows[2] = '{14432, 1'b0, 8'h00, 8'hC0, 1'b0}; // 16000 -> 0
    rows[3] = '{2341,  1'b0, 8'h00, 8'hC0, 1'b0}; // 14431 -> 0
    rows[4] = '{2342,  1'b0, 8'h00, 8'hE0, 1'b0}; // 2340 -> 32
    rows[5] = '{301,   1'b0, 8'h00, 8'hDF, 1'b0}; // 2341 -> 31
    rows[6] = '{2274,  1'b0, 8'h00, 8'hFF, 1'b0}; // 300 -> 63
    rows[7] = '{16400, 1'b0, 8'h00, 8'hE0, 1'b1}; // 2273 -> 32, then silence
    rows[8] = '{1137,  1'b1, 8'h20, 8'h20, 1'b0}; // timed out; edge re-arms only
    rows[9] = '{1137,  1'b0, 8'h00, 8'hEC, 1'b1}; // 1136 -> 44

    reset = 1'b0;
    cycles(3);
    reset = 1'b1;
    cycles(1);
    read_chk(1'b1, BASE, 8'h00, "reset_base");
    read_chk(1'b1, 16'hFF21, 8'h00, "reset_other");
    check("reset_dut4", data_out2, 8'h00);

    fork
      begin
        for (int i = 0; i < 10; i++) begin
          if (rows[i].pre)
            read_chk(1'b1, BASE, rows[i].pre_exp, $sformatf("row%0d_pre", i));
          tone_in = 1'b1;
          cycles(40);
          tone_in = 1'b0;
          cycles(40);
          read_chk(1'b1, BASE, rows[i].exp, $sformatf("row%0d", i));
          if (rows[i].wr) begin
            bus_write(BASE);
            read_chk(1'b1, BASE, rows[i].exp & 8'hBF, $sformatf("row%0d_clr", i));
          end
          cycles(rows[i].gap - 80 - (rows[i].wr ? 1 : 0));
        end
      end
      begin
        // 4 MHz instance: 9092 clocks between edges is 2273 us
        tone2 = 1'b1;
        cycles(40);
        tone2 = 1'b0;
        cycles(40);
        check("f4m_first_edge", data_out2, 8'h00);
        cycles(9012);
        tone2 = 1'b1;
        cycles(40);
        tone2 = 1'b0;
        cycles(160);
        check("f4m_tone32", data_out2, 8'hE0);
      end
    join

    // Edge C (1136 -> 44), edge D ten clocks into its search, write on DONE
    tone_in = 1'b1;
    cycles(5);
    tone_in = 1'b0;
    cycles(8);
    tone_in = 1'b1;
    cycles(5);
    tone_in = 1'b0;
    cycles(12);
    read_chk(1'b1, BASE, 8'hAC, "mid_search_prev");
    cycles(18);
    bus_write(BASE);
    read_chk(1'b1, BASE, 8'hEC, "done_write_new");
    cycles(150);
    read_chk(1'b1, BASE, 8'hEC, "no_second_update");
    bus_write(16'hFF21);
    read_chk(1'b1, BASE, 8'hEC, "write_other_addr");
    read_chk(1'b1, 16'hFF21, 8'h00, "read_other_addr");
    read_chk(1'b0, BASE, 8'h00, "read_disabled");

    // Edge F starts a long search; reset lands in the middle of it
    tone_in = 1'b1;
    cycles(30);
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
    read_chk(1'b1, BASE, 8'h00, "reset_mid_search");
    tone_in = 1'b0;
    cycles(100);
    read_chk(1'b1, BASE, 8'h00, "no_late_update");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
